// File: rtl/puf_response_collector.sv
// puf_response_collector
// Drives an arbiter-PUF delay chain. For each response bit it launches VOTES
// races on one challenge and waits SETTLE cycles after each launch before it
// samples the arbiter. The majority of the samples becomes the bit. The
// challenge then advances by a 16-bit Fibonacci LFSR.
// Optional build macro: PUF_STABILITY_EN adds unstable_cnt. This output counts
// the bits whose votes were not unanimous.
module puf_response_collector #(
    parameter int RESP_W = 32,
    parameter int SETTLE = 4,
    parameter int VOTES  = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [15:0]       seed,
    input  logic              arb_q,
    output logic [15:0]       challenge,
    output logic              launch,
    output logic [RESP_W-1:0] response,
    output logic              busy,
    output logic              done
`ifdef PUF_STABILITY_EN
    ,
    output logic [7:0]        unstable_cnt
`endif
);

    localparam int              IDX_W       = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(RESP_W - 1);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [3:0]      VOTES_N     = 4'(VOTES);
    localparam logic [3:0]      HALF_VOTES  = 4'(VOTES / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DECIDE,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       chal_reg, chal_next;
    logic [RESP_W-1:0] resp_reg, resp_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [3:0]        vote_reg, vote_next;
    logic [3:0]        ones_reg, ones_next;
    logic [7:0]        settle_reg, settle_next;
`ifdef PUF_STABILITY_EN
    logic [7:0]        unst_reg, unst_next;
`endif

    logic [15:0] chal_lfsr;
    logic        decided_bit;

    // Next challenge: shift left, feedback from taps 15,13,12,10 into bit 0
    assign chal_lfsr   = {chal_reg[14:0], chal_reg[15] ^ chal_reg[13] ^ chal_reg[12] ^ chal_reg[10]};
    // Strict majority of ones among the VOTES samples of this bit
    assign decided_bit = (ones_reg > HALF_VOTES);

    // State register and datapath registers, async reset to the idle/zero state
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg  <= ST_IDLE;
            chal_reg   <= 16'h0000;
            resp_reg   <= '0;
            idx_reg    <= '0;
            vote_reg   <= 4'd0;
            ones_reg   <= 4'd0;
            settle_reg <= 8'd0;
`ifdef PUF_STABILITY_EN
            unst_reg   <= 8'd0;
`endif
        end else begin
            state_reg  <= state_next;
            chal_reg   <= chal_next;
            resp_reg   <= resp_next;
            idx_reg    <= idx_next;
            vote_reg   <= vote_next;
            ones_reg   <= ones_next;
            settle_reg <= settle_next;
`ifdef PUF_STABILITY_EN
            unst_reg   <= unst_next;
`endif
        end
    end

    // Next-state and datapath update; everything holds unless a state changes it
    always_comb begin
        state_next  = state_reg;
        chal_next   = chal_reg;
        resp_next   = resp_reg;
        idx_next    = idx_reg;
        vote_next   = vote_reg;
        ones_next   = ones_reg;
        settle_next = settle_reg;
`ifdef PUF_STABILITY_EN
        unst_next   = unst_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next  = ST_LAUNCH;
                    // An all-zero challenge would lock the LFSR, so substitute all-ones
                    chal_next   = (seed == 16'h0000) ? 16'hFFFF : seed;
                    resp_next   = '0;
                    idx_next    = '0;
                    vote_next   = 4'd0;
                    ones_next   = 4'd0;
                    settle_next = 8'd0;
`ifdef PUF_STABILITY_EN
                    unst_next   = 8'd0;
`endif
                end
            end
            ST_LAUNCH: begin
                state_next  = ST_SETTLE;
                settle_next = 8'd0;
            end
            ST_SETTLE: begin
                if (settle_reg == SETTLE_LAST) begin
                    state_next = ST_SAMPLE;
                end else begin
                    settle_next = settle_reg + 8'd1;
                end
            end
            ST_SAMPLE: begin
                ones_next = ones_reg + {3'b000, arb_q};
                vote_next = vote_reg + 4'd1;
                if ((vote_reg + 4'd1) < VOTES_N) begin
                    state_next = ST_LAUNCH;
                end else begin
                    state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                resp_next = {resp_reg[RESP_W-2:0], decided_bit};
                chal_next = chal_lfsr;
                vote_next = 4'd0;
                ones_next = 4'd0;
`ifdef PUF_STABILITY_EN
                if ((ones_reg != 4'd0) && (ones_reg != VOTES_N) && (unst_reg != 8'hFF)) begin
                    unst_next = unst_reg + 8'd1;
                end
`endif
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx_reg + IDX_W'(1);
                    state_next = ST_LAUNCH;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign challenge = chal_reg;
    assign response  = resp_reg;
    assign launch    = (state_reg == ST_LAUNCH);
    assign done      = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
`ifdef PUF_STABILITY_EN
    assign unstable_cnt = unst_reg;
`endif

endmodule
